// File: rtl/latch_wr_pkg.sv
// Shared types and elaboration-time helpers for the latch bank writer.
// Holds the sequencer state encoding, width helpers and parameter legality.
package latch_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GATE  = 2'd2,
    HOLD  = 2'd3
  } wr_state_e;

  localparam int unsigned MIN_PHASE_CYC = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Down-counter must hold the longest phase length.
  function automatic int unsigned cnt_width(input int unsigned s, input int unsigned g,
                                            input int unsigned h);
    return $clog2(max3(s, g, h) + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit params_legal(input int unsigned depth, input int unsigned width,
                                      input int unsigned s, input int unsigned g,
                                      input int unsigned h);
    return (depth >= 1) && (width >= 1) &&
           (s >= MIN_PHASE_CYC) && (g >= MIN_PHASE_CYC) && (h >= MIN_PHASE_CYC);
  endfunction

endpackage

// File: rtl/latch_bank_writer_if.sv
// Request handshake and latch-array bus between a register-file front end
// (master) and the latch bank writer (slave).
interface latch_bank_writer_if
  import latch_wr_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) ();

  localparam int unsigned AW = addr_width(DEPTH);

  logic             req_valid;
  logic             req_ready;
  logic             req_clr;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] lat_d;
  logic [DEPTH-1:0] lat_ge;
  logic             lat_rst;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_clr, req_addr, req_data,
    input  req_ready, lat_d, lat_ge, lat_rst, done, err
  );

  modport slave (
    input  req_valid, req_clr, req_addr, req_data,
    output req_ready, lat_d, lat_ge, lat_rst, done, err
  );

endinterface

// File: rtl/latch_ge_decode.sv
// Registered one-hot gate-enable decoder with out-of-range detection.
// Drives no gate at all when the address falls outside the bank.
module latch_ge_decode #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [DEPTH-1:0] ge_o,
  output logic             oor_o
);

  logic [DEPTH-1:0] ge_d;
  logic [DEPTH-1:0] ge_q;
  logic             oor_d;
  logic             oor_q;

  always_comb begin
    ge_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ge_d[i] = en_i && (32'(addr_i) == i);
    end
    oor_d = en_i && (ge_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ge_q  <= '0;
      oor_q <= 1'b0;
    end else begin
      ge_q  <= ge_d;
      oor_q <= oor_d;
    end
  end

  assign ge_o  = ge_q;
  assign oor_o = oor_q;

endmodule

// File: rtl/latch_bank_writer.sv
// Write sequencer for a bank of transparent latches: holds LAT_D stable for
// whole-cycle setup/hold windows around each gate-enable or clear pulse.
module latch_bank_writer
  import latch_wr_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned GATE_CYC  = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst,
  latch_bank_writer_if.slave wr_if
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned CW = cnt_width(SETUP_CYC, GATE_CYC, HOLD_CYC);

  if (!params_legal(DEPTH, WIDTH, SETUP_CYC, GATE_CYC, HOLD_CYC)) begin : g_bad_params
    $error("latch_bank_writer: DEPTH/WIDTH and all phase lengths must be >= 1");
  end

  wr_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] lat_d_q, lat_d_d;
  logic             clr_q, clr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             err_flag_q, err_flag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             lat_rst_q, lat_rst_d;
  logic             ge_en;
  logic             dec_oor;
  logic [DEPTH-1:0] dec_ge;
  logic             xfer;

  // ready_q is only ever set while idle, so it alone qualifies the transfer.
  assign xfer = wr_if.req_valid && ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      lat_d_q    <= '0;
      clr_q      <= 1'b0;
      addr_q     <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lat_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      lat_d_q    <= lat_d_d;
      clr_q      <= clr_d;
      addr_q     <= addr_d;
      err_flag_q <= err_flag_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lat_rst_q  <= lat_rst_d;
    end
  end

  // Next-state: each phase reloads the counter on entry and advances at 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    lat_d_d    = lat_d_q;
    clr_d      = clr_q;
    addr_d     = addr_q;
    err_flag_d = err_flag_q | dec_oor;
    done_d     = 1'b0;
    err_d      = 1'b0;
    lat_rst_d  = 1'b0;
    ge_en      = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (xfer) begin
          state_d    = SETUP;
          cnt_d      = CW'(SETUP_CYC);
          ready_d    = 1'b0;
          clr_d      = wr_if.req_clr;
          addr_d     = wr_if.req_addr;
          lat_d_d    = wr_if.req_clr ? '0 : wr_if.req_data;
          err_flag_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(1)) begin
          state_d   = GATE;
          cnt_d     = CW'(GATE_CYC);
          ge_en     = ~clr_q;
          lat_rst_d = clr_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GATE: begin
        if (cnt_q == CW'(1)) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC);
        end else begin
          cnt_d     = cnt_q - CW'(1);
          ge_en     = ~clr_q;
          lat_rst_d = clr_q;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = err_flag_q;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  latch_ge_decode #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ge_decode (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ge_en),
    .addr_i (addr_q),
    .ge_o   (dec_ge),
    .oor_o  (dec_oor)
  );

  assign wr_if.req_ready = ready_q;
  assign wr_if.lat_d     = lat_d_q;
  assign wr_if.lat_ge    = dec_ge;
  assign wr_if.lat_rst   = lat_rst_q;
  assign wr_if.done      = done_q;
  assign wr_if.err       = err_q;

endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: three configurations driven with directed then
// random requests, compared each cycle against a phase-timing reference model.
module tb_latch_bank_writer;

  localparam int NI = 3;
  localparam int PD [NI] = '{8, 6, 8};
  localparam int PS [NI] = '{1, 1, 2};
  localparam int PG [NI] = '{1, 1, 3};
  localparam int PH [NI] = '{1, 1, 2};

  typedef struct packed {
    logic       clr;
    logic [2:0] addr;
    logic [7:0] data;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       drv_valid [NI];
  logic       drv_clr   [NI];
  logic [2:0] drv_addr  [NI];
  logic [7:0] drv_data  [NI];

  logic       obs_rdy  [NI];
  logic [7:0] obs_ge   [NI];
  logic [7:0] obs_d    [NI];
  logic       obs_rst  [NI];
  logic       obs_done [NI];
  logic       obs_err  [NI];

  latch_bank_writer_if #(.DEPTH(8), .WIDTH(8)) if0 ();
  latch_bank_writer_if #(.DEPTH(6), .WIDTH(8)) if1 ();
  latch_bank_writer_if #(.DEPTH(8), .WIDTH(8)) if2 ();

  latch_bank_writer #(.DEPTH(8), .WIDTH(8), .SETUP_CYC(1), .GATE_CYC(1), .HOLD_CYC(1))
    u_dut0 (.clk(clk), .rst(rst), .wr_if(if0));
  latch_bank_writer #(.DEPTH(6), .WIDTH(8), .SETUP_CYC(1), .GATE_CYC(1), .HOLD_CYC(1))
    u_dut1 (.clk(clk), .rst(rst), .wr_if(if1));
  latch_bank_writer #(.DEPTH(8), .WIDTH(8), .SETUP_CYC(2), .GATE_CYC(3), .HOLD_CYC(2))
    u_dut2 (.clk(clk), .rst(rst), .wr_if(if2));

  assign if0.req_valid = drv_valid[0];
  assign if0.req_clr   = drv_clr[0];
  assign if0.req_addr  = drv_addr[0];
  assign if0.req_data  = drv_data[0];
  assign if1.req_valid = drv_valid[1];
  assign if1.req_clr   = drv_clr[1];
  assign if1.req_addr  = drv_addr[1];
  assign if1.req_data  = drv_data[1];
  assign if2.req_valid = drv_valid[2];
  assign if2.req_clr   = drv_clr[2];
  assign if2.req_addr  = drv_addr[2];
  assign if2.req_data  = drv_data[2];

  assign obs_rdy[0]  = if0.req_ready;
  assign obs_ge[0]   = 8'(if0.lat_ge);
  assign obs_d[0]    = if0.lat_d;
  assign obs_rst[0]  = if0.lat_rst;
  assign obs_done[0] = if0.done;
  assign obs_err[0]  = if0.err;
  assign obs_rdy[1]  = if1.req_ready;
  assign obs_ge[1]   = 8'(if1.lat_ge);
  assign obs_d[1]    = if1.lat_d;
  assign obs_rst[1]  = if1.lat_rst;
  assign obs_done[1] = if1.done;
  assign obs_err[1]  = if1.err;
  assign obs_rdy[2]  = if2.req_ready;
  assign obs_ge[2]   = 8'(if2.lat_ge);
  assign obs_d[2]    = if2.lat_d;
  assign obs_rst[2]  = if2.lat_rst;
  assign obs_done[2] = if2.done;
  assign obs_err[2]  = if2.err;

  // Reference model: t = cycles since the accept cycle of the in-flight request.
  bit         m_busy [NI];
  int         m_t    [NI];
  bit         m_rdy  [NI];
  logic [7:0] m_d    [NI];
  bit         m_clr  [NI];
  int         m_addr [NI];
  bit         m_done [NI];
  bit         m_acc  [NI];

  bit         rand_en [NI];
  req_t       dq      [NI][$];
  logic [7:0] prev_ge [NI];
  logic [7:0] prev_d  [NI];
  bit         inv_ok  [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 1'b0;
      m_t[k]    = 0;
      m_rdy[k]  = 1'b0;
      m_d[k]    = 8'h00;
      m_done[k] = 1'b0;
      m_acc[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      m_acc[k]  = 1'b0;
      m_done[k] = 1'b0;
      if (!rst) begin
        if (m_busy[k]) begin
          m_t[k]++;
          if (m_t[k] == PS[k] + PG[k] + PH[k] + 1) begin
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
          end
        end else if (m_rdy[k] && drv_valid[k]) begin
          m_acc[k]  = 1'b1;
          m_busy[k] = 1'b1;
          m_t[k]    = 1;
          m_clr[k]  = drv_clr[k];
          m_addr[k] = int'(drv_addr[k]);
          m_d[k]    = drv_clr[k] ? 8'h00 : drv_data[k];
        end
        m_rdy[k] = !m_busy[k];
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      bit         in_gate;
      logic [7:0] e_ge;
      in_gate = m_busy[k] && (m_t[k] > PS[k]) && (m_t[k] <= PS[k] + PG[k]);
      e_ge = (in_gate && !m_clr[k] && m_addr[k] < PD[k]) ? (8'h01 << m_addr[k]) : 8'h00;
      chk($sformatf("i%0d_ready", k), 32'(obs_rdy[k]), 32'(m_rdy[k]));
      chk($sformatf("i%0d_lat_ge", k), 32'(obs_ge[k]), 32'(e_ge));
      chk($sformatf("i%0d_lat_rst", k), 32'(obs_rst[k]), 32'(in_gate && m_clr[k]));
      chk($sformatf("i%0d_lat_d", k), 32'(obs_d[k]), 32'(m_d[k]));
      chk($sformatf("i%0d_done", k), 32'(obs_done[k]), 32'(m_done[k]));
      if (m_done[k])
        chk($sformatf("i%0d_err", k), 32'(obs_err[k]),
            32'(!m_clr[k] && m_addr[k] >= PD[k]));
      chk($sformatf("i%0d_inv_onehot", k), 32'($countones(obs_ge[k]) > 1), 32'(0));
      chk($sformatf("i%0d_inv_excl", k), 32'((obs_ge[k] != 8'h00) && obs_rst[k]), 32'(0));
      if (inv_ok[k] && !rst)
        chk($sformatf("i%0d_inv_ge_d", k),
            32'((obs_ge[k] != prev_ge[k]) && (obs_d[k] != prev_d[k])), 32'(0));
      prev_ge[k] = obs_ge[k];
      prev_d[k]  = obs_d[k];
      inv_ok[k]  = !rst;
    end
  endtask

  task automatic next_req(input int k);
    req_t r;
    if (dq[k].size() > 0) begin
      r = dq[k].pop_front();
      drv_valid[k] = 1'b1;
      drv_clr[k]   = r.clr;
      drv_addr[k]  = r.addr;
      drv_data[k]  = r.data;
    end else if (rand_en[k] && $urandom_range(3) != 0) begin
      drv_valid[k] = 1'b1;
      drv_clr[k]   = ($urandom_range(5) == 0);
      drv_addr[k]  = 3'($urandom_range(7));
      drv_data[k]  = 8'($urandom_range(255));
    end else begin
      drv_valid[k] = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    for (int k = 0; k < NI; k++)
      if (m_acc[k] || !drv_valid[k]) next_req(k);
  endtask

  initial begin
    int n;
    for (int k = 0; k < NI; k++) begin
      drv_valid[k] = 1'b0;
      drv_clr[k]   = 1'b0;
      drv_addr[k]  = 3'd0;
      drv_data[k]  = 8'h00;
      rand_en[k]   = 1'b0;
      inv_ok[k]    = 1'b0;
      prev_ge[k]   = 8'h00;
      prev_d[k]    = 8'h00;
      m_clr[k]     = 1'b0;
      m_addr[k]    = 0;
    end
    reset_model();
    dq[0].push_back('{clr: 1'b0, addr: 3'd3, data: 8'hA5});
    dq[0].push_back('{clr: 1'b0, addr: 3'd0, data: 8'h11});
    dq[0].push_back('{clr: 1'b0, addr: 3'd7, data: 8'h22});
    dq[0].push_back('{clr: 1'b1, addr: 3'd4, data: 8'hFF});
    dq[1].push_back('{clr: 1'b0, addr: 3'd7, data: 8'h3C});
    dq[1].push_back('{clr: 1'b0, addr: 3'd5, data: 8'h96});
    dq[1].push_back('{clr: 1'b0, addr: 3'd6, data: 8'h42});
    dq[2].push_back('{clr: 1'b0, addr: 3'd1, data: 8'h5A});
    dq[2].push_back('{clr: 1'b1, addr: 3'd0, data: 8'h77});

    // Requests presented during reset must be ignored.
    repeat (3) cycle();
    #2 rst = 1'b0;

    repeat (30) cycle();
    for (int k = 0; k < NI; k++) rand_en[k] = 1'b1;
    repeat (400) cycle();

    // Reset in the middle of a gate pulse on instance 0.
    rand_en[0] = 1'b0;
    n = 0;
    while ((m_busy[0] || drv_valid[0]) && n < 60) begin cycle(); n++; end
    chk("drain_before_reset", 32'(m_busy[0] || drv_valid[0]), 32'(0));
    dq[0].push_back('{clr: 1'b0, addr: 3'd2, data: 8'hC3});
    n = 0;
    while (!(m_busy[0] && m_t[0] == PS[0] + 1) && n < 20) begin cycle(); n++; end
    chk("reach_gate", 32'(m_busy[0] && m_t[0] == PS[0] + 1), 32'(1));
    chk("gate_before_reset", 32'(obs_ge[0]), 32'(8'h04));
    #2 rst = 1'b1;
    reset_model();
    #1;
    chk("async_rst_ge", 32'(obs_ge[0]), 32'(0));
    check_all();
    repeat (2) cycle();
    #2 rst = 1'b0;
    cycle();
    chk("ready_after_reset", 32'(obs_rdy[0]), 32'(1));

    for (int k = 0; k < NI; k++) rand_en[k] = 1'b1;
    repeat (150) cycle();
    for (int k = 0; k < NI; k++) rand_en[k] = 1'b0;
    repeat (40) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
